// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame constants, receiver states and the event record.
`timescale 1ns/1ps
package ps2_pkg;

    localparam int          PS2_FRAME_BITS = 11;
    localparam logic [7:0]  PS2_EXT_CODE   = 8'hE0;
    localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK
    } rx_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    function automatic logic is_prefix(input logic [7:0] code);
        return (code == PS2_EXT_CODE) || (code == PS2_BREAK_CODE);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, overflow pulse and pop-while-full passthrough.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push & ~do_push;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is not reset; the pointers and count define what is valid, and head is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_rx_event.sv
// PS/2 keyboard receiver: synchronise, filter, deserialise, validate and fold E0/F0 prefixes
// into make/break events queued in a FIFO.
`timescale 1ns/1ps
module ps2_rx_event
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          PS2clk,
    input  logic                          key_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], key_data};
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // The filter counts consecutive samples that disagree with the filtered level.
    logic [FW-1:0] filt_cnt;
    logic          filt_clk;
    logic          fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_cnt <= '0;
            filt_clk <= 1'b1;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s;
                filt_cnt <= '0;
                fall     <= ~clk_s;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    rx_state_t                   state;
    logic [3:0]                  bitcnt;
    logic [PS2_FRAME_BITS-1:1]   frame;
    logic [TW-1:0]               tmo_cnt;
    logic                        ext_f;
    logic                        brk_f;
    logic [7:0]                  code;
    logic                        frame_ok;
    logic                        push;
    ps2_event_t                  push_evt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        code     = frame[8:1];
        frame_ok = (^frame[9:1]) & frame[10];
        push     = 1'b0;
        push_evt = '{ext: ext_f, brk: brk_f, code: code};
        if (state == CHECK && frame_ok && !is_prefix(code)) push = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bitcnt    <= '0;
            frame     <= '0;
            tmo_cnt   <= '0;
            ext_f     <= 1'b0;
            brk_f     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (fall) begin
                        if (data_s) begin
                            frame_err <= 1'b1;
                        end else begin
                            state  <= RECV;
                            bitcnt <= 4'd1;
                        end
                    end
                end
                RECV: begin
                    if (fall) begin
                        frame[bitcnt] <= data_s;
                        bitcnt        <= bitcnt + 1'b1;
                        tmo_cnt       <= '0;
                        if (bitcnt == 4'(PS2_FRAME_BITS - 1)) state <= CHECK;
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                        ext_f     <= 1'b0;
                        brk_f     <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (!frame_ok) begin
                        frame_err <= 1'b1;
                        ext_f     <= 1'b0;
                        brk_f     <= 1'b0;
                    end else if (code == PS2_EXT_CODE) begin
                        ext_f <= 1'b1;
                    end else if (code == PS2_BREAK_CODE) begin
                        brk_f <= 1'b1;
                    end else begin
                        // Flags are consumed by this event even if the FIFO drops it.
                        ext_f <= 1'b0;
                        brk_f <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ps2_event_t fifo_head;
    logic       fifo_full;
    logic       fifo_empty;

    sync_fifo #(
        .WIDTH ($bits(ps2_event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_evt),
        .pop       (evt_ready),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .overflow  (overflow)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_code  = fifo_head.code;
    assign evt_ext   = fifo_head.ext;
    assign evt_break = fifo_head.brk;

endmodule

// File: tb/tb_ps2_rx_event.sv
// Directed bench for ps2_rx_event: a 12.5 kHz PS/2 bus model against a 500 kHz system clock.
`timescale 1ns/1ps
module tb_ps2_rx_event;

    localparam int SS  = 2;
    localparam int FL  = 4;
    localparam int TMO = 200;
    localparam int FD  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       PS2clk;
    logic       key_data;
    logic       evt_ready;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       frame_err;
    logic       overflow;
    logic [3:0] fifo_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;
    int fall_cyc = 0;
    int rx_cyc = 0;
    int e0;
    logic [9:0] rx_q[$];

    always #1000 clk = ~clk;

    ps2_rx_event #(
        .SYNC_STAGES    (SS),
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TMO),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PS2clk     (PS2clk),
        .key_data   (key_data),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_break  (evt_break),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer-side monitor: logs every accepted event and counts error/overflow pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (evt_valid && evt_ready) begin
                rx_q.push_back({evt_ext, evt_break, evt_code});
                rx_cyc = cyc;
            end
            if (frame_err) err_cnt++;
            if (overflow)  ovf_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        key_data = b;
        tick(10);
        PS2clk   = 1'b0;
        fall_cyc = cyc;
        tick(20);
        PS2clk = 1'b1;
        tick(10);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic par_flip = 1'b0,
                              input logic stop = 1'b1, input int nbits = 11);
        logic [10:0] bits;
        bits = {stop, (~^code) ^ par_flip, code, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(bits[i]);
        key_data = 1'b1;
        tick(20);
    endtask

    function automatic logic [9:0] q_at(input int idx);
        return (idx < rx_q.size()) ? rx_q[idx] : 10'h3FF;
    endfunction

    initial begin
        reset     = 1'b1;
        PS2clk    = 1'b1;
        key_data  = 1'b1;
        evt_ready = 1'b0;
        tick(3);
        check("rst_valid",  evt_valid,  0);
        check("rst_count",  fifo_count, 0);
        check("rst_code",   evt_code,   0);
        check("rst_err",    frame_err,  0);
        check("rst_ovf",    overflow,   0);
        reset = 1'b0;
        tick(10);

        // Single frame: code 0x1C, consumer always ready; valid appears sync+filter+2 cycles after the stop fall.
        evt_ready = 1'b1;
        rx_q.delete();
        e0 = err_cnt;
        send_frame(8'h1C);
        check("t1_events",  rx_q.size(), 1);
        check("t1_evt",     q_at(0), 10'h01C);
        check("t1_latency", rx_cyc - fall_cyc, SS + FL + 2);
        check("t1_err",     err_cnt - e0, 0);

        // Prefix folding: F0 1C -> break 1C; E0 F0 75 -> ext break 75.
        rx_q.delete();
        send_frame(8'hF0);
        send_frame(8'h1C);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        check("t2_events", rx_q.size(), 2);
        check("t2_evt0",   q_at(0), 10'h11C);
        check("t2_evt1",   q_at(1), 10'h375);
        check("t2_err",    err_cnt - e0, 0);

        // Bad parity, then bad stop, then a good 0x32.
        evt_ready = 1'b0;
        rx_q.delete();
        send_frame(8'h1C, 1'b1);
        check("t3_par_err",   err_cnt - e0, 1);
        check("t3_par_count", fifo_count, 0);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("t3_stop_err",   err_cnt - e0, 2);
        check("t3_stop_count", fifo_count, 0);
        send_frame(8'h32);
        check("t3_good_count", fifo_count, 1);
        evt_ready = 1'b1;
        tick(2);
        check("t3_good_evt", q_at(0), 10'h032);
        check("t3_err",      err_cnt - e0, 2);

        // Timeout after 5 bits also drops a pending break prefix.
        rx_q.delete();
        e0 = err_cnt;
        send_frame(8'hF0);
        send_frame(8'h55, 1'b0, 1'b1, 5);
        tick(TMO);
        check("t4_tmo_err", err_cnt - e0, 1);
        check("t4_no_evt",  rx_q.size(), 0);
        send_frame(8'h1C);
        check("t4_events", rx_q.size(), 1);
        check("t4_evt",    q_at(0), 10'h01C);

        // Overflow: 9 frames into an 8-deep FIFO, then drain in order.
        evt_ready = 1'b0;
        rx_q.delete();
        e0 = err_cnt;
        begin
            int o0;
            o0 = ovf_cnt;
            for (int i = 0; i < 9; i++) send_frame(8'h11 + 8'(i));
            check("t5_count_full", fifo_count, 8);
            check("t5_ovf",        ovf_cnt - o0, 1);
            check("t5_err",        err_cnt - e0, 0);
        end
        evt_ready = 1'b1;
        tick(10);
        evt_ready = 1'b0;
        check("t5_drained", rx_q.size(), 8);
        for (int i = 0; i < 8; i++) check($sformatf("t5_order%0d", i), q_at(i), 10'h011 + 10'(i));
        check("t5_count_empty", fifo_count, 0);

        // Reset with 3 queued events and a frame in flight.
        for (int i = 0; i < 3; i++) send_frame(8'h21 + 8'(i));
        check("t6_queued", fifo_count, 3);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        key_data = 1'b1;
        tick(10);
        PS2clk = 1'b0;
        tick(10);
        reset = 1'b1;
        tick(3);
        check("t6_rst_valid", evt_valid,  0);
        check("t6_rst_count", fifo_count, 0);
        PS2clk   = 1'b1;
        key_data = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(100);
        check("t6_post_count", fifo_count, 0);
        check("t6_post_valid", evt_valid,  0);
        evt_ready = 1'b1;
        rx_q.delete();
        e0 = err_cnt;
        send_frame(8'h1C);
        check("t6_evt", q_at(0), 10'h01C);

        // Glitches of FILTER_LEN-1 cycles on PS2clk must not be sampled as bits.
        rx_q.delete();
        e0 = err_cnt;
        key_data = 1'b1;
        PS2clk   = 1'b0;
        tick(FL - 1);
        PS2clk = 1'b1;
        tick(30);
        check("t7_glitch_err", err_cnt - e0, 0);
        key_data = 1'b0;
        PS2clk   = 1'b0;
        tick(FL - 1);
        PS2clk = 1'b1;
        tick(10);
        key_data = 1'b1;
        tick(30);
        send_frame(8'h1C);
        check("t7_events", rx_q.size(), 1);
        check("t7_evt",    q_at(0), 10'h01C);
        check("t7_err",    err_cnt - e0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx_event.md
Name: ps2_rx_event

Overview:
- Parametrised successor to the keyboard PS/2 receiver.
- Synchronises and filters PS2clk/key_data into the clk domain and deserialises full 11-bit frames: start, 8 data LSB-first, odd parity, stop.
- Validates each frame, aborts stalled frames on timeout, and folds E0/F0 prefixes into make/break key events.
- Events are buffered in a FIFO with a valid/ready interface toward the game input/control logic.

Parameters:
- SYNC_STAGES, 2: flip-flop synchroniser depth on PS2clk and key_data (min 2).
- FILTER_LEN, 4: consecutive equal synchronised samples needed before filtered PS2clk changes.
- TIMEOUT_CYCLES, 20000: clk cycles without a filtered falling edge before a partial frame is aborted.
- FIFO_DEPTH, 8: event FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- PS2clk  in  1  raw PS/2 clock from keyboard.
- key_data  in  1  raw PS/2 data from keyboard.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts head; pop when evt_valid & evt_ready.
- evt_code  out  8  scancode at FIFO head.
- evt_ext  out  1  head event was E0-prefixed.
- evt_break  out  1  head event was F0-prefixed (key release).
- frame_err  out  1  one-cycle pulse on a parity, start, stop or timeout error.
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - All outputs return to 0.
  - Synchroniser and filter registers load 1 (idle bus).
  - FIFO is emptied; prefix flags, bit counter and timeout counter are cleared; FSM goes to IDLE.
- Filter:
  - Filtered PS2clk changes only after FILTER_LEN consecutive equal synchronised samples.
  - fall pulse = filtered 1->0 transition, one cycle wide.
  - Data is sampled from synchronised key_data in the fall cycle.
- Receiver FSM:
  - IDLE: on fall, sample the start bit.
    - Sampled 1: pulse frame_err, stay IDLE.
    - Sampled 0: go RECV with bitcnt=1.
  - RECV: each fall stores the bit at index bitcnt, then bitcnt++. After bit 10 (stop) is stored, go CHECK.
  - RECV timeout: the counter resets on every fall. Reaching TIMEOUT_CYCLES-1 aborts to IDLE, pulses frame_err and clears the prefix flags.
  - CHECK (exactly one cycle): the frame is valid iff data bits plus parity bit have an odd count of ones AND stop = 1.
    - Invalid: pulse frame_err, clear prefix flags.
    - Valid: pass to prefix stage. Always return to IDLE.
- Prefix stage (in the CHECK cycle):
  - 0xE0: set ext_f, no event.
  - 0xF0: set brk_f, no event.
  - Any other code: push {ext_f, brk_f, code} and clear both flags. The flags clear even if the push is dropped.
- FIFO:
  - Push is issued in the CHECK cycle (cycle N+1, N = stop-bit fall cycle).
  - The entry is visible on evt_* from cycle N+2.
  - evt_* show the head entry combinationally from storage. They are 0 when empty.
  - Pointers use log2(FIFO_DEPTH) bits and wrap modulo depth.
  - Push while full without a simultaneous pop: drop the entry, pulse overflow, leave contents unchanged.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: the push occurs, the pop is ignored (evt_valid was 0).
  - fifo_count updates on the cycle after each push/pop.
- Errors never write the FIFO. frame_err and overflow never assert in the same cycle.

Decomposition:
- Shared package ps2_pkg holds:
  - constants PS2_FRAME_BITS=11, PS2_EXT_CODE=8'hE0, PS2_BREAK_CODE=8'hF0;
  - rx_state_t enum {IDLE, RECV, CHECK};
  - ps2_event_t struct {ext, brk, code[7:0]}.
- One natural sub-module: sync_fifo (parametrised width/depth, full/empty/count, same-cycle push/pop rules above). Reusable for the other input paths.

Test Plan:
- Single frame 0x1C (parity 0, stop 1) at 12.5 kHz bus, evt_ready=1 -> one event: code 0x1C, ext 0, break 0; evt_valid high at cycle N+2 after the stop fall.
- Frames F0,1C then E0,F0,75 -> events {0x1C, break=1, ext=0} then {0x75, ext=1, break=1}; no event for any prefix byte.
- Frame 0x1C with parity bit 1 -> frame_err pulse, fifo_count stays 0. Frame with stop=0 -> same. A following good 0x32 is accepted normally.
- Stop toggling PS2clk after 5 bits, wait TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE. Next complete 0x1C frame yields a correct event.
- evt_ready=0, send 9 frames with FIFO_DEPTH=8 -> fifo_count=8 and one overflow pulse on the 9th. Then pop all: codes come out in order.
- Assert reset midway through a frame and with 3 queued events -> evt_valid=0, fifo_count=0, no event from the partial frame. Glitch on PS2clk shorter than FILTER_LEN cycles -> no bit sampled.
